// File: rtl/bp_cce_operand_fetch.sv
// CCE microcode operand fetch: registers src_a/src_b behind a valid/yumi handshake.
// Optional GPR write-back bypass: BP_CCE_OPERAND_FETCH_BYPASS_EN.
// mshr_i layout (MSB->LSB): flags, req_lce, req_addr[39:0], req_way, lru_addr[39:0], lru_way, owner_lce, owner_way, next_coh_state.
module bp_cce_operand_fetch #(
  parameter int num_gpr_p         = 8,
  parameter int gpr_width_p       = 64,
  parameter int num_flags_p       = 16,
  parameter int num_lce_p         = 8,
  parameter int num_cce_p         = 4,
  parameter int lce_assoc_p       = 8,
  parameter int coh_state_width_p = 3,
  parameter int cce_id_width_p    = 6,
  localparam int lg_gpr_lp        = $clog2(num_gpr_p),
  localparam int lg_lce_lp        = $clog2(num_lce_p),
  localparam int lg_assoc_lp      = $clog2(lce_assoc_p),
  localparam int paddr_width_lp   = 40,
  localparam int mshr_width_lp    = num_flags_p + 2*lg_lce_lp + 2*paddr_width_lp
                                    + 3*lg_assoc_lp + coh_state_width_p
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  input  logic [1:0]                             src_a_sel_i,
  input  logic [1:0]                             src_b_sel_i,
  input  logic [lg_gpr_lp-1:0]                   gpr_a_sel_i,
  input  logic [lg_gpr_lp-1:0]                   gpr_b_sel_i,
  input  logic [3:0]                             flag_a_sel_i,
  input  logic [3:0]                             flag_b_sel_i,
  input  logic [3:0]                             special_a_sel_i,
  input  logic [3:0]                             special_b_sel_i,
  input  logic [gpr_width_p-1:0]                 imm_i,
  input  logic [num_gpr_p*gpr_width_p-1:0]       gpr_i,
  input  logic [mshr_width_lp-1:0]               mshr_i,
  input  logic [cce_id_width_p-1:0]              cce_id_i,
  input  logic [num_lce_p-1:0]                   sharers_hits_i,
  input  logic [num_lce_p*lg_assoc_lp-1:0]       sharers_ways_i,
  input  logic [num_lce_p*coh_state_width_p-1:0] sharers_states_i,
`ifdef BP_CCE_OPERAND_FETCH_BYPASS_EN
  input  logic                                   wb_v_i,
  input  logic [lg_gpr_lp-1:0]                   wb_gpr_i,
  input  logic [gpr_width_p-1:0]                 wb_data_i,
`endif
  output logic                                   v_o,
  input  logic                                   yumi_i,
  output logic [gpr_width_p-1:0]                 src_a_o,
  output logic [gpr_width_p-1:0]                 src_b_o,
  output logic                                   idx_err_o
);

  typedef enum logic [1:0] {
    e_src_sel_gpr     = 2'd0,
    e_src_sel_flag    = 2'd1,
    e_src_sel_special = 2'd2,
    e_src_sel_imm     = 2'd3
  } bp_cce_inst_src_sel_e;

  typedef enum logic [3:0] {
    e_src_flags          = 4'd0,
    e_src_cce_id         = 4'd1,
    e_src_num_lce        = 4'd2,
    e_src_num_cce        = 4'd3,
    e_src_req_lce        = 4'd4,
    e_src_req_addr       = 4'd5,
    e_src_req_way        = 4'd6,
    e_src_next_coh_state = 4'd7,
    e_src_lru_addr       = 4'd8,
    e_src_lru_way        = 4'd9,
    e_src_owner_lce      = 4'd10,
    e_src_owner_way      = 4'd11,
    e_src_sharers_hit    = 4'd12,
    e_src_sharers_way    = 4'd13,
    e_src_sharers_state  = 4'd14
  } bp_cce_inst_src_special_e;

  typedef struct packed {
    logic [num_flags_p-1:0]       flags;
    logic [lg_lce_lp-1:0]         req_lce;
    logic [paddr_width_lp-1:0]    req_addr;
    logic [lg_assoc_lp-1:0]       req_way;
    logic [paddr_width_lp-1:0]    lru_addr;
    logic [lg_assoc_lp-1:0]       lru_way;
    logic [lg_lce_lp-1:0]         owner_lce;
    logic [lg_assoc_lp-1:0]       owner_way;
    logic [coh_state_width_p-1:0] next_coh_state;
  } bp_cce_mshr_s;

  bp_cce_mshr_s mshr;
  assign mshr = mshr_i;

  function automatic logic is_sharers(input logic [3:0] sel);
    return (sel == e_src_sharers_hit) || (sel == e_src_sharers_way)
        || (sel == e_src_sharers_state);
  endfunction

  // Sharers specials resolve to sh_val, which the caller zeroes for src_b.
  function automatic logic [gpr_width_p-1:0] special_f(
    input logic [3:0]                sel,
    input bp_cce_mshr_s              m,
    input logic [cce_id_width_p-1:0] id,
    input logic [gpr_width_p-1:0]    sh_val
  );
    case (sel)
      e_src_flags:          return gpr_width_p'(m.flags);
      e_src_cce_id:         return gpr_width_p'(id);
      e_src_num_lce:        return gpr_width_p'(num_lce_p);
      e_src_num_cce:        return gpr_width_p'(num_cce_p);
      e_src_req_lce:        return gpr_width_p'(m.req_lce);
      e_src_req_addr:       return gpr_width_p'(m.req_addr);
      e_src_req_way:        return gpr_width_p'(m.req_way);
      e_src_next_coh_state: return gpr_width_p'(m.next_coh_state);
      e_src_lru_addr:       return gpr_width_p'(m.lru_addr);
      e_src_lru_way:        return gpr_width_p'(m.lru_way);
      e_src_owner_lce:      return gpr_width_p'(m.owner_lce);
      e_src_owner_way:      return gpr_width_p'(m.owner_way);
      e_src_sharers_hit,
      e_src_sharers_way,
      e_src_sharers_state:  return sh_val;
      default:              return '0;
    endcase
  endfunction

  function automatic logic [gpr_width_p-1:0] operand_f(
    input logic [1:0]             src_sel,
    input logic [gpr_width_p-1:0] gpr_val,
    input logic [3:0]             flag_sel,
    input logic [15:0]            flags_ext,
    input logic [gpr_width_p-1:0] special_val,
    input logic [gpr_width_p-1:0] imm
  );
    case (src_sel)
      e_src_sel_gpr:     return gpr_val;
      e_src_sel_flag:    return gpr_width_p'(flags_ext[flag_sel]);
      e_src_sel_special: return special_val;
      e_src_sel_imm:     return imm;
      default:           return '0;
    endcase
  endfunction

  logic [gpr_width_p-1:0] gpr_eff [num_gpr_p];
  logic [gpr_width_p-1:0] gpr_a_val, gpr_b_val, sh_val;
  logic [lg_lce_lp-1:0]   sh_idx;
  logic                   sh_oob;
  logic [15:0]            flags_ext;
  logic [gpr_width_p-1:0] src_a_d, src_b_d;
  logic                   idx_err_d;

  always_comb begin
    for (int i = 0; i < num_gpr_p; i++) begin
      gpr_eff[i] = gpr_i[i*gpr_width_p +: gpr_width_p];
`ifdef BP_CCE_OPERAND_FETCH_BYPASS_EN
      if (wb_v_i && (wb_gpr_i == lg_gpr_lp'(i))) gpr_eff[i] = wb_data_i;
`endif
    end
  end

  assign gpr_a_val = gpr_eff[gpr_a_sel_i];
  assign gpr_b_val = gpr_eff[gpr_b_sel_i];
  // Flags beyond num_flags_p read as zero through the zero-padded vector.
  assign flags_ext = 16'(mshr.flags);

  // Range check uses the whole GPR so large indices cannot alias a valid LCE.
  assign sh_idx = gpr_b_val[lg_lce_lp-1:0];
  assign sh_oob = (gpr_b_val >= gpr_width_p'(num_lce_p));

  always_comb begin
    sh_val = '0;
    if (!sh_oob) begin
      case (special_a_sel_i)
        e_src_sharers_hit:   sh_val = gpr_width_p'(sharers_hits_i[sh_idx]);
        e_src_sharers_way:   sh_val = gpr_width_p'(sharers_ways_i[sh_idx*lg_assoc_lp +: lg_assoc_lp]);
        e_src_sharers_state: sh_val = gpr_width_p'(sharers_states_i[sh_idx*coh_state_width_p +: coh_state_width_p]);
        default:             sh_val = '0;
      endcase
    end
  end

  always_comb begin
    src_a_d   = operand_f(src_a_sel_i, gpr_a_val, flag_a_sel_i, flags_ext,
                          special_f(special_a_sel_i, mshr, cce_id_i, sh_val), imm_i);
    src_b_d   = operand_f(src_b_sel_i, gpr_b_val, flag_b_sel_i, flags_ext,
                          special_f(special_b_sel_i, mshr, cce_id_i, '0), imm_i);
    idx_err_d = (src_a_sel_i == e_src_sel_special) && is_sharers(special_a_sel_i) && sh_oob;
  end

  logic                   v_q;
  logic [gpr_width_p-1:0] src_a_q, src_b_q;
  logic                   idx_err_q;
  logic                   accept;

  assign ready_o = ~v_q | yumi_i;
  assign accept  = v_i & ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q       <= 1'b0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      idx_err_q <= 1'b0;
    end else if (accept) begin
      v_q       <= 1'b1;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      idx_err_q <= idx_err_d;
    end else if (yumi_i) begin
      v_q       <= 1'b0;
    end
  end

  assign v_o       = v_q;
  assign src_a_o   = src_a_q;
  assign src_b_o   = src_b_q;
  assign idx_err_o = idx_err_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !v_q)) else $error("yumi_i asserted while v_o is low");
  end
`endif

endmodule

// File: tb/tb_bp_cce_operand_fetch.sv
// Directed-vector bench for bp_cce_operand_fetch; bypass checks when
// BP_CCE_OPERAND_FETCH_BYPASS_EN is defined.
module tb_bp_cce_operand_fetch;

  localparam logic [1:0] S_GPR = 2'd0, S_FLAG = 2'd1, S_SPEC = 2'd2, S_IMM = 2'd3;
  localparam logic [3:0] P_FLAGS = 4'd0, P_CCE_ID = 4'd1, P_NUM_LCE = 4'd2, P_NUM_CCE = 4'd3,
                         P_REQ_LCE = 4'd4, P_REQ_ADDR = 4'd5, P_REQ_WAY = 4'd6, P_NEXT_COH = 4'd7,
                         P_LRU_ADDR = 4'd8, P_LRU_WAY = 4'd9, P_OWN_LCE = 4'd10, P_OWN_WAY = 4'd11,
                         P_SH_HIT = 4'd12, P_SH_WAY = 4'd13, P_SH_STATE = 4'd14, P_NONE = 4'd15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         v_i = 1'b0, yumi_i = 1'b0;
  logic         ready_o, v_o, idx_err_o;
  logic [1:0]   src_a_sel, src_b_sel;
  logic [2:0]   gpr_a_sel, gpr_b_sel;
  logic [3:0]   flag_a_sel, flag_b_sel, special_a_sel, special_b_sel;
  logic [63:0]  imm;
  logic [511:0] gpr;
  logic [113:0] mshr;
  logic [5:0]   cce_id;
  logic [7:0]   hits;
  logic [23:0]  ways, states;
  logic [63:0]  src_a_o, src_b_o;
`ifdef BP_CCE_OPERAND_FETCH_BYPASS_EN
  logic         wb_v = 1'b0;
  logic [2:0]   wb_gpr = '0;
  logic [63:0]  wb_data = '0;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bp_cce_operand_fetch dut (
    .clk_i(clk), .reset_i(reset), .v_i(v_i), .ready_o(ready_o),
    .src_a_sel_i(src_a_sel), .src_b_sel_i(src_b_sel),
    .gpr_a_sel_i(gpr_a_sel), .gpr_b_sel_i(gpr_b_sel),
    .flag_a_sel_i(flag_a_sel), .flag_b_sel_i(flag_b_sel),
    .special_a_sel_i(special_a_sel), .special_b_sel_i(special_b_sel),
    .imm_i(imm), .gpr_i(gpr), .mshr_i(mshr), .cce_id_i(cce_id),
    .sharers_hits_i(hits), .sharers_ways_i(ways), .sharers_states_i(states),
`ifdef BP_CCE_OPERAND_FETCH_BYPASS_EN
    .wb_v_i(wb_v), .wb_gpr_i(wb_gpr), .wb_data_i(wb_data),
`endif
    .v_o(v_o), .yumi_i(yumi_i), .src_a_o(src_a_o), .src_b_o(src_b_o), .idx_err_o(idx_err_o)
  );

  typedef struct {
    logic [1:0]  sa, sb;
    logic [2:0]  ga, gb;
    logic [3:0]  fa, fb, pa, pb;
    logic [63:0] imm;
    logic [63:0] ea, eb;
    logic        eerr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [1:0] sa, input logic [1:0] sb,
                              input logic [2:0] ga, input logic [2:0] gb,
                              input logic [3:0] fa, input logic [3:0] fb,
                              input logic [3:0] pa, input logic [3:0] pb,
                              input logic [63:0] im, input logic [63:0] ea,
                              input logic [63:0] eb, input logic eerr);
    vec_t v;
    v.sa = sa; v.sb = sb; v.ga = ga; v.gb = gb; v.fa = fa; v.fb = fb;
    v.pa = pa; v.pb = pb; v.imm = im; v.ea = ea; v.eb = eb; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input vec_t v);
    src_a_sel = v.sa; src_b_sel = v.sb; gpr_a_sel = v.ga; gpr_b_sel = v.gb;
    flag_a_sel = v.fa; flag_b_sel = v.fb; special_a_sel = v.pa; special_b_sel = v.pb;
    imm = v.imm;
  endtask

  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, " v_o"}, {63'd0, v_o}, 64'd1);
    chk({nm, " src_a"}, src_a_o, v.ea);
    chk({nm, " src_b"}, src_b_o, v.eb);
    chk({nm, " idx_err"}, {63'd0, idx_err_o}, {63'd0, v.eerr});
  endtask

  // Accept one vector from an empty stage, check it, then drain.
  task automatic run_vec(input string nm, input vec_t v);
    drive(v);
    v_i = 1'b1; yumi_i = 1'b0;
    @(posedge clk); #1;
    chk_out(nm, v);
    v_i = 1'b0; yumi_i = 1'b1;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    chk({nm, " drained"}, {63'd0, v_o}, 64'd0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " v_o"}, {63'd0, v_o}, 64'd0);
    chk({nm, " src_a"}, src_a_o, 64'd0);
    chk({nm, " src_b"}, src_b_o, 64'd0);
    chk({nm, " idx_err"}, {63'd0, idx_err_o}, 64'd0);
    chk({nm, " ready"}, {63'd0, ready_o}, 64'd1);
  endtask

  initial begin
    logic [63:0] gv [8];
    gv[0] = 64'd8; gv[1] = 64'h1111_2222_3333_4444; gv[2] = 64'd5; gv[3] = 64'h55;
    gv[4] = 64'h10; gv[5] = '1; gv[6] = 64'd9; gv[7] = 64'd7;
    for (int k = 0; k < 8; k++) gpr[k*64 +: 64] = gv[k];
    mshr = {16'h8001, 3'd3, 40'h12_3456_789A, 3'd5, 40'hAB_CDEF_0123, 3'd2, 3'd6, 3'd7, 3'd4};
    cce_id = 6'h2A;
    hits = 8'hA4;
    for (int k = 0; k < 8; k++) begin
      ways[k*3 +: 3]   = 3'((k + 1) % 8);
      states[k*3 +: 3] = 3'((k * 3) % 8);
    end

    vecs[0]  = mk(S_GPR,  S_IMM,  3, 0, 0, 0, 0, 0, 64'h1234, 64'h55, 64'h1234, 0);
    vecs[1]  = mk(S_FLAG, S_SPEC, 0, 0, 0, 0, 0, P_FLAGS, 0, 64'd1, 64'h8001, 0);
    vecs[2]  = mk(S_FLAG, S_FLAG, 0, 0, 15, 1, 0, 0, 0, 64'd1, 64'd0, 0);
    vecs[3]  = mk(S_SPEC, S_SPEC, 0, 0, 0, 0, P_NUM_LCE, P_NUM_CCE, 0, 64'd8, 64'd4, 0);
    vecs[4]  = mk(S_SPEC, S_SPEC, 0, 0, 0, 0, P_CCE_ID, P_REQ_LCE, 0, 64'h2A, 64'd3, 0);
    vecs[5]  = mk(S_SPEC, S_SPEC, 0, 0, 0, 0, P_REQ_ADDR, P_REQ_WAY, 0, 64'h12_3456_789A, 64'd5, 0);
    vecs[6]  = mk(S_SPEC, S_SPEC, 0, 0, 0, 0, P_NEXT_COH, P_LRU_ADDR, 0, 64'd4, 64'hAB_CDEF_0123, 0);
    vecs[7]  = mk(S_SPEC, S_SPEC, 0, 0, 0, 0, P_LRU_WAY, P_OWN_LCE, 0, 64'd2, 64'd6, 0);
    vecs[8]  = mk(S_SPEC, S_SPEC, 0, 0, 0, 0, P_OWN_WAY, P_NONE, 0, 64'd7, 64'd0, 0);
    vecs[9]  = mk(S_SPEC, S_GPR,  0, 2, 0, 0, P_SH_WAY, 0, 0, 64'd6, 64'd5, 0);
    vecs[10] = mk(S_SPEC, S_GPR,  0, 6, 0, 0, P_SH_WAY, 0, 0, 64'd0, 64'd9, 1);
    vecs[11] = mk(S_SPEC, S_GPR,  0, 7, 0, 0, P_SH_HIT, 0, 0, 64'd1, 64'd7, 0);
    vecs[12] = mk(S_SPEC, S_GPR,  0, 2, 0, 0, P_SH_STATE, 0, 0, 64'd7, 64'd5, 0);
    vecs[13] = mk(S_SPEC, S_GPR,  0, 0, 0, 0, P_SH_HIT, 0, 0, 64'd0, 64'd8, 1);
    vecs[14] = mk(S_GPR,  S_SPEC, 5, 2, 0, 0, 0, P_SH_WAY, 0, '1, 64'd0, 0);
    vecs[15] = mk(S_GPR,  S_GPR,  4, 1, 0, 0, 0, 0, 0, 64'h10, 64'h1111_2222_3333_4444, 0);

    // Reset holds off a valid request.
    drive(vecs[0]);
    reset = 1'b1; v_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk_reset("reset_with_v");
    end
    v_i = 1'b0; reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Stall: outputs hold while inputs change and ready_o stays low.
    drive(vecs[0]); v_i = 1'b1; yumi_i = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      drive(vecs[c + 3]);
      @(posedge clk); #1;
      chk_out($sformatf("stall%0d", c), vecs[0]);
      chk($sformatf("stall%0d ready", c), {63'd0, ready_o}, 64'd0);
    end
    // Release with a new request: no bubble, then back-to-back.
    drive(vecs[3]); yumi_i = 1'b1;
    #1 chk("release ready", {63'd0, ready_o}, 64'd1);
    @(posedge clk); #1;
    chk_out("release", vecs[3]);
    drive(vecs[1]);
    @(posedge clk); #1;
    chk_out("b2b", vecs[1]);
    v_i = 1'b0;
    @(posedge clk); #1;
    yumi_i = 1'b0;
    chk("drain v_o", {63'd0, v_o}, 64'd0);
    chk("drain hold a", src_a_o, 64'd1);
    chk("drain hold b", src_b_o, 64'h8001);

`ifdef BP_CCE_OPERAND_FETCH_BYPASS_EN
    wb_v = 1'b1; wb_gpr = 3'd4; wb_data = 64'h99;
    run_vec("bypass_a", mk(S_GPR, S_GPR, 4, 4, 0, 0, 0, 0, 0, 64'h99, 64'h99, 0));
    wb_gpr = 3'd2; wb_data = 64'd3;
    run_vec("bypass_idx", mk(S_SPEC, S_GPR, 0, 2, 0, 0, P_SH_WAY, 0, 0, 64'd4, 64'd3, 0));
    wb_v = 1'b0;
    run_vec("bypass_off", mk(S_GPR, S_GPR, 4, 2, 0, 0, 0, 0, 0, 64'h10, 64'd5, 0));
`else
    run_vec("no_bypass", mk(S_GPR, S_IMM, 4, 0, 0, 0, 0, 0, 64'h77, 64'h10, 64'h77, 0));
`endif

    // Reset discards a stalled operand pair.
    drive(vecs[10]); v_i = 1'b1; yumi_i = 1'b0;
    @(posedge clk); #1;
    chk_out("pre_reset", vecs[10]);
    v_i = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk_reset("reset_inflight");
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bp_cce_operand_fetch.md
Name: bp_cce_operand_fetch

Overview:
- Registered two-operand fetch stage for the CCE microcode pipeline. It sits between instruction decode and the ALU/branch units.
- Selects src_a and src_b independently from GPRs, MSHR flags, special registers or immediate.
- Supports indexed reads of the directory sharers vectors, with the index taken from the src_b GPR.
- Presents both operands one cycle later behind a valid/yumi handshake.

Parameters:
- num_gpr_p, 8, number of GPRs; must be a power of 2.
- gpr_width_p, 64, width of GPRs, immediate and operands.
- num_flags_p, 16, number of MSHR flag bits.
- num_lce_p, 8, number of LCEs; sets sharers vector length.
- num_cce_p, 4, number of CCEs; returned by e_src_num_cce.
- lce_assoc_p, 8, LCE associativity; sets way width.
- coh_state_width_p, 3, width of a sharers coherence state.
- cce_id_width_p, 6, CCE id width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- v_i  in  1  decoded instruction valid
- ready_o  out  1  stage can accept (ready-and)
- src_a_sel_i / src_b_sel_i  in  2 each  bp_cce_inst_src_sel_e
- gpr_a_sel_i / gpr_b_sel_i  in  lg(num_gpr_p) each  GPR index
- flag_a_sel_i / flag_b_sel_i  in  4 each  flag index
- special_a_sel_i / special_b_sel_i  in  4 each  bp_cce_inst_src_special_e
- imm_i  in  gpr_width_p  immediate
- gpr_i  in  num_gpr_p*gpr_width_p  GPR file contents
- mshr_i  in  mshr_width_lp  MSHR, decoded with bp_cce_mshr_s
- cce_id_i  in  cce_id_width_p  this CCE's id
- sharers_hits_i  in  num_lce_p  sharers hit bits
- sharers_ways_i  in  num_lce_p*lg(lce_assoc_p)  sharers ways
- sharers_states_i  in  num_lce_p*coh_state_width_p  sharers states
- v_o  out  1  operands valid
- yumi_i  in  1  consumer takes operands
- src_a_o / src_b_o  out  gpr_width_p each  operands
- idx_err_o  out  1  sharers index was out of range

Behaviour:
- Reset: v_o=0, src_a_o=0, src_b_o=0, idx_err_o=0. Reset overrides v_i and yumi_i in the same cycle; an in-flight operand is discarded.
- ready_o = ~v_o | yumi_i.
- Accept occurs when v_i & ready_o. On accept, the next cycle has v_o=1 with operands computed from the inputs at the accept edge. Latency is exactly 1 cycle; back-to-back accepts give 1 operand pair per cycle.
- yumi_i & ~(v_i & ready_o): v_o goes to 0 and the data registers hold their last values.
- v_o & ~yumi_i: all outputs are held stable; ready_o=0; inputs are ignored.
- yumi_i asserted while v_o=0 is illegal; an assertion fires in simulation.
- Per-operand selection (identical for a and b):
  - gpr: gpr_i[sel].
  - flag: bit 0 = mshr.flags[idx]; idx >= num_flags_p gives 0.
  - imm: imm_i.
  - special: flags, cce_id, num_lce, num_cce, req_lce, req_addr, req_way, next_coh_state, lru_addr, lru_way, owner_lce, owner_way; each zero-extended or truncated to gpr_width_p.
- Sharers specials (hit/way/state), src_a only:
  - Index = gpr_i[gpr_b_sel_i], using its low lg(num_lce_p) bits.
  - If the full GPR value >= num_lce_p, src_a = 0 and idx_err_o = 1 for that operand pair.
  - Otherwise src_a = the selected hit, way or state field, zero-extended, and idx_err_o = 0.
  - A sharers special selected on src_b gives 0 with idx_err_o = 0.
- Unused or default encodings give 0.

Optional Feature:
- Macro: BP_CCE_OPERAND_FETCH_BYPASS_EN.
- Defined:
  - Adds ports wb_v_i (1), wb_gpr_i (lg(num_gpr_p)) and wb_data_i (gpr_width_p).
  - When wb_v_i=1 and wb_gpr_i equals a selected GPR, wb_data_i is used in place of gpr_i for that GPR in the accept cycle. This covers src_a GPR, src_b GPR and the sharers index.
- Undefined: the ports are absent and gpr_i is used directly.

Test Plan:
- Reset with v_i=1 held -> v_o=0, src_a_o=0, src_b_o=0. First accept after reset deasserted: gpr_a=3 (gpr_i[3]=0x55), src_b=imm 0x1234 -> next cycle v_o=1, src_a_o=0x55, src_b_o=0x1234.
- Stall: v_o=1, yumi_i=0 for 3 cycles while inputs change -> outputs stable, ready_o=0. Then yumi_i=1 with v_i=1 -> new pair appears the next cycle, no bubble.
- Sharers: num_lce_p=8, gpr_i[2]=5, gpr_b_sel=2, special_a=e_src_sharers_way, sharers_ways[5]=6 -> src_a_o=6, idx_err_o=0. gpr_i[2]=9 -> src_a_o=0, idx_err_o=1.
- Flags: mshr.flags=16'h8001, flag_a=0, special_b=e_src_flags -> src_a_o=1, src_b_o=0x8001. Special num_lce -> 8.
- Bypass (macro defined): gpr_i[4]=0x10, wb_v_i=1, wb_gpr_i=4, wb_data_i=0x99, gpr_a=4 -> src_a_o=0x99. Without the macro -> src_a_o=0x10.
- Reset asserted while v_o=1, yumi_i=0 -> next cycle v_o=0, src_a_o=0, src_b_o=0, idx_err_o=0, ready_o=1.
